// File: rtl/pipe_io_pkg.sv
// pipe_io_pkg: shared constants and address decode helper for the pipelined
// CPU's memory-mapped I/O bank.
//   - Word offsets of the register regions inside the 128-byte window.
//   - Channel count limits checked at elaboration.
//   - decode_region(): classifies a window offset into a register region.
package pipe_io_pkg;

  localparam logic [6:0] OUT_BASE_OFF = 7'h00;
  localparam logic [6:0] IN_BASE_OFF  = 7'h40;
  localparam logic [6:0] MASK_OFF     = 7'h78;
  localparam logic [6:0] STATUS_OFF   = 7'h7C;

  localparam int MAX_OUT = 16;
  localparam int MAX_IN  = 14;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_OUT,
    RGN_IN,
    RGN_MASK,
    RGN_STATUS
  } region_e;

  // Byte lanes are ignored: only the word part of the offset is compared.
  // Bits [5:2] of the offset index the channel inside the OUT or IN region.
  function automatic region_e decode_region(input logic [6:0] off,
                                            input int num_out,
                                            input int num_in);
    logic [6:0] word_off;
    logic [3:0] idx;
    region_e    rgn;
    word_off = {off[6:2], 2'b00};
    idx      = off[5:2];
    rgn      = RGN_NONE;
    if (word_off == STATUS_OFF) begin
      rgn = RGN_STATUS;
    end else if (word_off == MASK_OFF) begin
      rgn = RGN_MASK;
    end else if (word_off >= IN_BASE_OFF) begin
      if (int'(idx) < num_in) rgn = RGN_IN;
    end else if (word_off >= OUT_BASE_OFF) begin
      if (int'(idx) < num_out) rgn = RGN_OUT;
    end
    return rgn;
  endfunction

endpackage

// File: rtl/io_sync_edge.sv
// io_sync_edge: two-flop synchroniser for one asynchronous input channel,
// followed by a "previous value" register used for change detection.
// Ports:
//   clock   - system clock
//   resetn  - asynchronous active-low reset
//   din     - asynchronous external input (IN_W bits)
//   sync    - synchronised value (second flop)
//   change  - high while the synchronised value differs from the previous one
module io_sync_edge #(
  parameter int IN_W = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [IN_W-1:0] din,
  output logic [IN_W-1:0] sync,
  output logic            change
);

  logic [IN_W-1:0] s1_reg;
  logic [IN_W-1:0] s2_reg;
  logic [IN_W-1:0] prev_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_reg   <= '0;
      s2_reg   <= '0;
      prev_reg <= '0;
    end else begin
      s1_reg   <= din;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
    end
  end

  assign sync   = s2_reg;
  // Because prev resets to zero, a nonzero level at reset release also
  // registers as a change once it reaches s2.
  assign change = (s2_reg != prev_reg);

endmodule

// File: rtl/sevenseg.sv
// sevenseg: hex digit to active-low seven-segment pattern.
// Ports:
//   value - 4-bit digit
//   seg   - segments {g,f,e,d,c,b,a}, 0 = lit
module sevenseg (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/pipe_io_bank.sv
// pipe_io_bank: memory-mapped I/O bank beside data RAM in the MEM stage.
// Ports:
//   clock, resetn   - system clock, asynchronous active-low reset
//   addr, wdata     - byte address and store data from the MEM stage
//   we, re          - store / load strobes
//   io_sel          - combinational: addr falls inside this bank's window
//   rdata, rvalid   - registered load data and its one-cycle valid pulse
//   in_ports        - NUM_IN asynchronous input channels, IN_W bits each
//   out_ports       - NUM_OUT output registers, DATA_W bits each
//   hex             - active-low seven-segment view of each output's low nibble
//   irq             - OR of (status AND mask)
module pipe_io_bank
  import pipe_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h0000_0080,
  parameter int          NUM_OUT = 6,
  parameter int          NUM_IN  = 2,
  parameter int          DATA_W  = 32,
  parameter int          IN_W    = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic                      we,
  input  logic                      re,
  output logic                      io_sel,
  output logic [31:0]               rdata,
  output logic                      rvalid,
  input  logic [NUM_IN*IN_W-1:0]    in_ports,
  output logic [NUM_OUT*DATA_W-1:0] out_ports,
  output logic [NUM_OUT*7-1:0]      hex,
  output logic                      irq
);

  // ---------------------------------------------------------------- checks
  if (IO_BASE[6:0] != 7'd0) begin : g_bad_base
    $error("pipe_io_bank: IO_BASE must be 128-byte aligned");
  end
  if (NUM_OUT < 1 || NUM_OUT > MAX_OUT) begin : g_bad_out
    $error("pipe_io_bank: NUM_OUT out of range 1..16");
  end
  if (NUM_IN < 1 || NUM_IN > MAX_IN) begin : g_bad_in
    $error("pipe_io_bank: NUM_IN out of range 1..14");
  end
  if (DATA_W < 4 || DATA_W > 32) begin : g_bad_dw
    $error("pipe_io_bank: DATA_W out of range 4..32");
  end
  if (IN_W < 1 || IN_W > 32) begin : g_bad_iw
    $error("pipe_io_bank: IN_W out of range 1..32");
  end

  // ---------------------------------------------------------------- decode
  region_e    region;
  logic [3:0] idx;
  logic       wr_acc;
  logic       rd_acc;
  logic       addr_lane_unused;

  assign io_sel           = (addr[31:7] == IO_BASE[31:7]);
  assign region           = decode_region(addr[6:0], NUM_OUT, NUM_IN);
  assign idx              = addr[5:2];
  assign addr_lane_unused = ^addr[1:0];

  // A simultaneous store and load is treated as a store only.
  assign wr_acc = we && io_sel;
  assign rd_acc = re && io_sel && !we;

  // ---------------------------------------------------------------- outputs
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
    logic [DATA_W-1:0] out_reg;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        out_reg <= '0;
      end else if (wr_acc && region == RGN_OUT && idx == 4'(gi)) begin
        out_reg <= wdata[DATA_W-1:0];
      end
    end

    assign out_ports[gi*DATA_W +: DATA_W] = out_reg;

    sevenseg u_seg (
      .value (out_reg[3:0]),
      .seg   (hex[gi*7 +: 7])
    );
  end

  // ---------------------------------------------------------------- inputs
  logic [NUM_IN*IN_W-1:0] in_sync;
  logic [NUM_IN-1:0]      change;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
    io_sync_edge #(
      .IN_W (IN_W)
    ) u_sync (
      .clock  (clock),
      .resetn (resetn),
      .din    (in_ports[gi*IN_W +: IN_W]),
      .sync   (in_sync[gi*IN_W +: IN_W]),
      .change (change[gi])
    );
  end

  // ---------------------------------------------------------------- status / mask
  logic [NUM_IN-1:0] status_reg;
  logic [NUM_IN-1:0] status_next;
  logic [NUM_IN-1:0] mask_reg;
  logic              status_rd;
  logic              status_wr;

  assign status_rd = rd_acc && region == RGN_STATUS;
  assign status_wr = wr_acc && region == RGN_STATUS;

  // A change always wins over a clear in the same cycle so no event is lost.
  always_comb begin
    status_next = status_reg;
    for (int j = 0; j < NUM_IN; j++) begin
      if (change[j]) begin
        status_next[j] = 1'b1;
      end else if (status_rd || (status_wr && wdata[j])) begin
        status_next[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      status_reg <= '0;
      mask_reg   <= '0;
    end else begin
      status_reg <= status_next;
      if (wr_acc && region == RGN_MASK) begin
        mask_reg <= wdata[NUM_IN-1:0];
      end
    end
  end

  assign irq = |(status_reg & mask_reg);

  // ---------------------------------------------------------------- read path
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    unique case (region)
      RGN_OUT: begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (idx == 4'(i)) rd_mux = 32'(out_ports[i*DATA_W +: DATA_W]);
        end
      end
      RGN_IN: begin
        for (int j = 0; j < NUM_IN; j++) begin
          if (idx == 4'(j)) rd_mux = 32'(in_sync[j*IN_W +: IN_W]);
        end
      end
      RGN_MASK:   rd_mux = 32'(mask_reg);
      RGN_STATUS: rd_mux = 32'(status_reg);   // value before this read's clear
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      if (rd_acc) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pipe_io_bank.sv
module tb_pipe_io_bank;

  logic         clock;
  logic         resetn;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         we;
  logic         re;
  logic         io_sel;
  logic [31:0]  rdata;
  logic         rvalid;
  logic [7:0]   in_ports;
  logic [191:0] out_ports;
  logic [41:0]  hex;
  logic         irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  pipe_io_bank dut (
    .clock     (clock),
    .resetn    (resetn),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .re        (re),
    .io_sel    (io_sel),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .in_ports  (in_ports),
    .out_ports (out_ports),
    .hex       (hex),
    .irq       (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s act=%0h", name, act);
    end else begin
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pulse consumes one expected read value.
  always @(negedge clock) begin
    if (resetn && rvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {224'd0, rdata}, 256'hDEAD_0000);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("read_data", {224'd0, rdata}, {224'd0, e});
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clock); #1;
    we = 1'b0; addr = 32'h0;
    $display("write addr=%08h data=%08h", a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
    addr = a; re = 1'b1;
    exp_q.push_back(e);
    @(posedge clock); #1;
    re = 1'b0; addr = 32'h0;
    $display("read  addr=%08h expect=%08h", a, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [191:0] exp_out;
    resetn = 1'b0; addr = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0; in_ports = 8'h0;

    // 1. reset state
    #1;
    check("rst_out_ports", {64'd0, out_ports}, 256'd0);
    check("rst_hex", {214'd0, hex}, {214'd0, {6{7'b1000000}}});
    check("rst_rdata", {224'd0, rdata}, 256'd0);
    check("rst_rvalid", {255'd0, rvalid}, 256'd0);
    check("rst_irq", {255'd0, irq}, 256'd0);
    #11 resetn = 1'b1;
    tick(3);
    bus_read(32'h0000_00FC, 32'h0);

    // 2. output register write / readback
    bus_write(32'h0000_0088, 32'h0000_000A);
    check("out2_write", {224'd0, out_ports[95:64]}, 256'hA);
    check("hex2_A", {249'd0, hex[20:14]}, {249'd0, 7'b0001000});
    bus_read(32'h0000_0088, 32'h0000_000A);
    check("rvalid_high", {255'd0, rvalid}, 256'd1);
    tick(1);
    check("rvalid_pulse_end", {255'd0, rvalid}, 256'd0);

    // 3. input change -> IN read, status flag, irq
    bus_write(32'h0000_00F8, 32'h2);
    in_ports = 8'h50;
    tick(2);
    check("irq_before_3rd_edge", {255'd0, irq}, 256'd0);
    bus_read(32'h0000_00C4, 32'h5);
    check("irq_after_change", {255'd0, irq}, 256'd1);

    // 4. STATUS read clears; change during read keeps flag
    bus_read(32'h0000_00FC, 32'h2);
    check("irq_after_status_read", {255'd0, irq}, 256'd0);
    in_ports = 8'hA0;
    tick(3);
    check("irq_second_change", {255'd0, irq}, 256'd1);
    in_ports = 8'h30;
    tick(2);
    bus_read(32'h0000_00FC, 32'h2);
    check("irq_change_beats_clear", {255'd0, irq}, 256'd1);
    bus_read(32'h0000_00FC, 32'h2);
    check("irq_cleared_again", {255'd0, irq}, 256'd0);

    // 5. write-1-to-clear, unmapped accesses, simultaneous we/re
    in_ports = 8'h00;
    tick(3);
    check("irq_flag_set", {255'd0, irq}, 256'd1);
    bus_write(32'h0000_00FC, 32'h1);
    check("w1c_other_bit", {255'd0, irq}, 256'd1);
    bus_write(32'h0000_00FC, 32'h2);
    check("w1c_clear", {255'd0, irq}, 256'd0);
    bus_read(32'h0000_00FC, 32'h0);
    bus_read(32'h0000_00F8, 32'h2);
    bus_read(32'h0000_00D0, 32'h0);
    bus_write(32'h0000_00E0, 32'hDEAD_BEEF);
    exp_out = '0;
    exp_out[95:64] = 32'hA;
    check("unmapped_write", {64'd0, out_ports}, {64'd0, exp_out});
    addr = 32'h0000_0088; wdata = 32'h5; we = 1'b1; re = 1'b1;
    @(posedge clock); #1;
    we = 1'b0; re = 1'b0; addr = 32'h0;
    $display("write+read addr=00000088 data=00000005");
    check("we_re_no_read", {255'd0, rvalid}, 256'd0);
    check("we_re_write_wins", {224'd0, out_ports[95:64]}, 256'h5);
    bus_write(32'h0000_0040, 32'h1);
    check("outside_window", {224'd0, out_ports[31:0]}, 256'd0);

    // 6. asynchronous reset aborts rvalid and clears outputs
    bus_write(32'h0000_0080, 32'hFF);
    check("out0_ff", {224'd0, out_ports[31:0]}, 256'hFF);
    addr = 32'h0000_0080; re = 1'b1;
    @(posedge clock); #1;
    check("abort_rvalid_before", {255'd0, rvalid}, 256'd1);
    check("abort_rdata_before", {224'd0, rdata}, 256'hFF);
    #1 resetn = 1'b0;
    #1;
    $display("async reset with re active");
    check("abort_rvalid", {255'd0, rvalid}, 256'd0);
    check("abort_out0", {224'd0, out_ports[31:0]}, 256'd0);
    check("abort_rdata", {224'd0, rdata}, 256'd0);
    check("abort_hex", {214'd0, hex}, {214'd0, {6{7'b1000000}}});
    re = 1'b0; addr = 32'h0;
    #10 resetn = 1'b1;
    tick(2);

    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_io_bank.md
Name: pipe_io_bank

Overview:
- Parametrised memory-mapped I/O bank serving the MEM stage of the pipelined CPU.
- Replaces fixed in_port0/1 and out_port0..5 wiring with NUM_IN input and NUM_OUT output channels.
- Adds input synchronisation, sticky change-detect status with interrupt mask, a registered read path and per-output seven-segment drive.
- Sits beside data RAM; MEM stage selects this block's read data when io_sel is high.

Parameters:
- IO_BASE, 32'h0000_0080: byte base address of the bank; must be 128-byte aligned.
- NUM_OUT, 6: output channels, 1..16.
- NUM_IN, 2: input channels, 1..14.
- DATA_W, 32: output register width, 4..32.
- IN_W, 4: input port width, 1..32.

Ports:
- clock, input, 1: system clock; all state on rising edge.
- resetn, input, 1: asynchronous active-low reset.
- addr, input, 32: byte address from malu.
- wdata, input, 32: store data from mb.
- we, input, 1: store strobe (mwmem).
- re, input, 1: load strobe (mm2reg).
- io_sel, output, 1: combinational; addr within [IO_BASE, IO_BASE+0x7F].
- rdata, output, 32: registered read data.
- rvalid, output, 1: high one cycle after an accepted read.
- in_ports, input, NUM_IN*IN_W: asynchronous external inputs; channel j at [j*IN_W +: IN_W].
- out_ports, output, NUM_OUT*DATA_W: output registers, packed the same way.
- hex, output, NUM_OUT*7: active-low segments of the low nibble of each output.
- irq, output, 1: OR of (status AND mask).

Behaviour:
- Reset is asynchronous and active-low. On reset: all out_ports, sync stages, prev, status, mask, rdata and rvalid = 0. irq = 0. hex shows "0".
- Address map (offset = addr - IO_BASE, word aligned; addr[1:0] ignored):
  - 0x00 + 4i: OUT[i], read/write, for i < NUM_OUT.
  - 0x40 + 4j: IN[j], read only; synchronised value zero-extended to 32 bits.
  - 0x78: MASK, read/write, low NUM_IN bits.
  - 0x7C: STATUS; read returns flags then clears them; writing 1 to a bit clears that bit.
  - Unmapped offsets read 0; writes to them are ignored.
- Writes: when we && io_sel, the target register updates at the rising edge with wdata[DATA_W-1:0]. Value is visible on out_ports the same edge.
- Reads: when re && io_sel && !we, rdata is loaded at the edge and rvalid pulses high for one cycle.
  - rdata holds its value until the next read.
  - we && re together: the write wins and no read occurs.
- Input path: 2-flop synchroniser (s1, s2), then prev <= s2.
  - change[j] = (s2 != prev) on any bit of channel j.
  - IN[j] reflects a pin change at the 2nd edge; status[j] sets at the 3rd edge.
  - A nonzero input at reset release therefore sets its flag.
- Status update, per bit, in priority order:
  1. set if change this cycle;
  2. else clear if a STATUS read, or a write-1 to that bit, is accepted;
  3. else hold.
  - A change in the same cycle as a clear leaves the flag set.
  - A STATUS read returns the pre-clear value.
- irq is combinational from the status and mask registers, so it drops the cycle after a clear.
- Reset asserted mid-operation aborts a pending rvalid; no partial writes.
- Out-of-range parameters are a synthesis-time error (generate assertion).

Decomposition:
- Package pipe_io_pkg holds:
  - offset constants OUT_BASE_OFF=0x00, IN_BASE_OFF=0x40, MASK_OFF=0x78, STATUS_OFF=0x7C;
  - limits MAX_OUT=16, MAX_IN=14.
- One sub-module, io_sync_edge: parametrised by IN_W; holds the 2-flop synchroniser, prev register and change output. Instantiated NUM_IN times.
- Existing sevenseg is instantiated per output through a generate loop.

Test Plan:
1. Reset with in_ports=0 -> out_ports=0, hex all = 7'b1000000, rdata=0, rvalid=0, irq=0; after 3 cycles, STATUS reads 0.
2. Store 0x0000_000A to IO_BASE+0x08 -> OUT[2]=0xA at that edge, hex[20:14]=7'b0001000. Load the same address -> rdata=0x0000000A with a one-cycle rvalid pulse.
3. Drive in_ports channel 1 from 0 to 4'h5 -> IN[1] reads 0x5 two edges later. STATUS bit1 sets at the 3rd edge; with MASK=0x2, irq=1.
4. Load STATUS (0x7C) -> returns 0x2 and the bit clears, irq=0 next cycle. Repeat with a new channel-1 change in the same cycle as the read -> bit1 remains 1.
5. Write 0x2 to STATUS with flag set -> cleared. Load IO_BASE+0x50 (unmapped for NUM_IN=2) -> rdata=0. Store to IO_BASE+0x60 -> no out_ports change.
6. Assert resetn low while re is active and OUT[0]=0xFF -> rvalid=0, OUT[0]=0 immediately, without waiting for a clock edge.
